// File: rtl/display_scheduler.sv
// Display path sequencer: arbitrates processor/debug requests, converts the
// granted 16-bit value to BCD by iterative double-dabble, then holds the digits.
module display_scheduler #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Proc_Req,
  input  logic [15:0] Proc_Value,
  output logic        Proc_Ack,
  input  logic        Dbg_Req,
  input  logic [15:0] Dbg_Value,
  output logic        Dbg_Ack,
  output logic [3:0]  Thousand,
  output logic [3:0]  Hundred,
  output logic [3:0]  Ten,
  output logic [3:0]  One,
  output logic        Overflow,
  output logic        Src,
  output logic        Busy,
  output logic        Valid
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > 16) ? HOLD_CYCLES : 16;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CONV_LAST = CW'(15);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CONVERT, SHOW} state_t;

  state_t        state, state_nxt;
  logic          ptr, ptr_nxt;      // 1 = debug side favoured on contention
  logic          grant, grant_nxt;  // 1 = debug side granted
  logic [CW-1:0] cnt;
  logic [15:0]   bin;
  logic [19:0]   bcd;
  logic [19:0]   bcd_adj;
  logic [19:0]   bcd_step;
  logic [15:0]   bin_step;

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      ptr   <= 1'b0;
      grant <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    Proc_Ack  = 1'b0;
    Dbg_Ack   = 1'b0;
    case (state)
      IDLE: begin
        if (Proc_Req && Dbg_Req) begin
          grant_nxt = ptr;
          ptr_nxt   = ~ptr;
          state_nxt = LOAD;
        end else if (Proc_Req) begin
          grant_nxt = 1'b0;
          ptr_nxt   = 1'b1;
          state_nxt = LOAD;
        end else if (Dbg_Req) begin
          grant_nxt = 1'b1;
          ptr_nxt   = 1'b0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        Proc_Ack  = ~grant;
        Dbg_Ack   = grant;
        state_nxt = CONVERT;
      end
      CONVERT: begin
        if (cnt == CONV_LAST) state_nxt = SHOW;
      end
      SHOW: begin
        if (cnt == HOLD_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: correct every BCD nibble >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign {bcd_step, bin_step} = {bcd_adj, bin} << 1;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt      <= '0;
      bin      <= '0;
      bcd      <= '0;
      Thousand <= '0;
      Hundred  <= '0;
      Ten      <= '0;
      One      <= '0;
      Overflow <= 1'b0;
      Src      <= 1'b0;
      Valid    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          bin <= grant ? Dbg_Value : Proc_Value;
          bcd <= '0;
          cnt <= '0;
        end
        CONVERT: begin
          bin <= bin_step;
          bcd <= bcd_step;
          if (cnt == CONV_LAST) begin
            cnt      <= '0;
            Thousand <= bcd_step[15:12];
            Hundred  <= bcd_step[11:8];
            Ten      <= bcd_step[7:4];
            One      <= bcd_step[3:0];
            Overflow <= |bcd_step[19:16];
            Src      <= grant;
            Valid    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == HOLD_LAST) cnt <= '0;
          else                  cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler: a transaction-level timeline model
// predicts grants and shown values; a monitor compares the DUT every cycle.
module tb_display_scheduler;

  localparam int unsigned HOLD = 4;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        Proc_Req = 1'b0;
  logic [15:0] Proc_Value = '0;
  logic        Proc_Ack;
  logic        Dbg_Req = 1'b0;
  logic [15:0] Dbg_Value = '0;
  logic        Dbg_Ack;
  logic [3:0]  Thousand, Hundred, Ten, One;
  logic        Overflow, Src, Busy, Valid;

  display_scheduler #(.HOLD_CYCLES(HOLD)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .Proc_Req(Proc_Req), .Proc_Value(Proc_Value), .Proc_Ack(Proc_Ack),
    .Dbg_Req(Dbg_Req), .Dbg_Value(Dbg_Value), .Dbg_Ack(Dbg_Ack),
    .Thousand(Thousand), .Hundred(Hundred), .Ten(Ten), .One(One),
    .Overflow(Overflow), .Src(Src), .Busy(Busy), .Valid(Valid)
  );

  initial forever #5 Clock = ~Clock;

  typedef struct {
    int unsigned ack_cyc;
    bit          src;
    logic [15:0] value;
  } txn_t;

  txn_t        sb[$];
  logic [15:0] pq[$];
  logic [15:0] dq[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Display expected for a value: {overflow, thousands, hundreds, tens, units}.
  function automatic logic [16:0] disp_of(logic [15:0] v);
    int unsigned x = v;
    return {(x > 9999) ? 1'b1 : 1'b0, 4'((x % 10000) / 1000), 4'((x % 1000) / 100),
            4'((x % 100) / 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] pick_value();
    logic [15:0] corners [0:7];
    corners = '{16'd0, 16'd9, 16'd10, 16'd999, 16'd1000, 16'd9999, 16'd10000, 16'd65535};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    return 16'($urandom);
  endfunction

  // Reference timeline: scheduler free at m_free; a request seen in cycle k is
  // acknowledged in k+1 and the scheduler is free again at k+18+HOLD.
  bit          m_ptr = 1'b0;
  int unsigned m_free = 0;

  always @(negedge Clock) begin
    if (!Resetn) begin
      m_ptr  = 1'b0;
      m_free = 0;
      sb.delete();
    end else if (cyc >= m_free && (Proc_Req || Dbg_Req)) begin
      txn_t t;
      t.src     = (Proc_Req && Dbg_Req) ? m_ptr : Dbg_Req;
      t.ack_cyc = cyc + 1;
      t.value   = t.src ? Dbg_Value : Proc_Value;
      m_ptr     = ~t.src;
      m_free    = cyc + 18 + HOLD;
      sb.push_back(t);
    end
  end

  // Monitor: expectations come only from scoreboard entries and their timing.
  txn_t        cur;
  bit          show_pending = 1'b0;
  int unsigned show_at = 0, busy_start = 0, busy_end = 0;
  logic [15:0] exp_digits = '0;
  logic        exp_ov = 1'b0, exp_src = 1'b0, exp_valid = 1'b0;
  logic [1:0]  exp_ack;

  always @(negedge Clock) begin
    if (!Resetn) begin
      check("reset_outputs",
            {Proc_Ack, Dbg_Ack, Busy, Valid, Src, Overflow, Thousand, Hundred, Ten, One}, '0);
      exp_digits   = '0;
      exp_ov       = 1'b0;
      exp_src      = 1'b0;
      exp_valid    = 1'b0;
      show_pending = 1'b0;
      busy_start   = 0;
      busy_end     = 0;
    end else begin
      exp_ack = 2'b00;
      while (sb.size() > 0 && sb[0].ack_cyc < cyc) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].ack_cyc == cyc) begin
        cur          = sb.pop_front();
        exp_ack      = cur.src ? 2'b01 : 2'b10;
        show_pending = 1'b1;
        show_at      = cyc + 17;
        busy_start   = cyc;
        busy_end     = cyc + 17 + HOLD;
      end
      check("ack", {Proc_Ack, Dbg_Ack}, exp_ack);
      if (show_pending && cyc == show_at) begin
        {exp_ov, exp_digits} = disp_of(cur.value);
        exp_src      = cur.src;
        exp_valid    = 1'b1;
        show_pending = 1'b0;
      end
      check("busy", Busy, (cyc >= busy_start && cyc < busy_end));
      check("display", {Valid, Src, Overflow, Thousand, Hundred, Ten, One},
            {exp_valid, exp_src, exp_ov, exp_digits});
    end
  end

  // Requesters: raise Req from the queues or at random, drop it the cycle after
  // Ack (unless held), and scramble the value once it has been captured.
  task automatic run_cycles(int unsigned n, bit hold_high, int unsigned rate);
    bit pa, da;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge Clock);
      pa = Proc_Ack;
      da = Dbg_Ack;
      @(posedge Clock);
      #1;
      if (pa) begin
        if (!hold_high) Proc_Req = 1'b0;
        if (hold_high && pq.size() > 0) Proc_Value = pq.pop_front();
        else                            Proc_Value = pick_value();
      end
      if (da) begin
        if (!hold_high) Dbg_Req = 1'b0;
        if (hold_high && dq.size() > 0) Dbg_Value = dq.pop_front();
        else                            Dbg_Value = pick_value();
      end
      if (!Proc_Req && !pa && (pq.size() > 0 || $urandom_range(0, 99) < rate)) begin
        Proc_Req = 1'b1;
        if (pq.size() > 0) Proc_Value = pq.pop_front();
        else               Proc_Value = pick_value();
      end
      if (!Dbg_Req && !da && (dq.size() > 0 || $urandom_range(0, 99) < rate)) begin
        Dbg_Req = 1'b1;
        if (dq.size() > 0) Dbg_Value = dq.pop_front();
        else               Dbg_Value = pick_value();
      end
    end
  endtask

  initial begin
    #1 Resetn = 1'b0;
    #1 check("reset_immediate",
             {Proc_Ack, Dbg_Ack, Busy, Valid, Src, Overflow, Thousand, Hundred, Ten, One}, '0);
    repeat (3) @(posedge Clock);
    #1 Resetn = 1'b1;

    pq.push_back(16'd1234);
    run_cycles(30, 1'b0, 0);

    pq.push_back(16'd42);
    dq.push_back(16'd9999);
    run_cycles(50, 1'b0, 0);

    run_cycles(100, 1'b1, 100);
    run_cycles(60, 1'b0, 0);

    dq.push_back(16'd65535);
    dq.push_back(16'd10000);
    dq.push_back(16'd0);
    run_cycles(80, 1'b0, 0);

    pq.push_back(16'd5678);
    run_cycles(30, 1'b0, 0);

    run_cycles(600, 1'b0, 20);
    run_cycles(60, 1'b0, 0);

    // Reset in the middle of a conversion with the processor request still held.
    pq.push_back(16'd777);
    run_cycles(1, 1'b1, 0);
    run_cycles(10, 1'b1, 0);
    #1 Resetn = 1'b0;
    #1 check("reset_mid_convert",
             {Proc_Ack, Dbg_Ack, Busy, Valid, Src, Overflow, Thousand, Hundred, Ten, One}, '0);
    @(negedge Clock);
    @(posedge Clock);
    #1 Resetn = 1'b1;
    run_cycles(60, 1'b0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
